serial_frame_receiver: RTL and testbench
========================================

# serial_frame_receiver

Downstream consumer of the 4-bit serial shift register chain. Samples the serial bit stream from the shift register output, detects a start bit, assembles DATA_W data bits LSB first, checks an optional even-parity bit and a stop bit, then presents the word in parallel. The word is held under a valid/ack handshake. Parity, framing and overrun faults are flagged.

## Interface
- DATA_W, default 4: data bits per frame (legal 1..16).
- PARITY_EN, default 1: 1 = parity bit present after the data bits; 0 = no parity bit, and Parity_err stays 0.
- CLK  in  1  system clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- Serial_in  in  1  serial bit stream; driven by shift_out of the shift register.
- Enable  in  1  bit strobe; Serial_in is sampled only on edges with Enable=1.
- Data_out  out  DATA_W  received word; bit 0 = first data bit received.
- Data_valid  out  1  Data_out holds an unconsumed word.
- Data_ack  in  1  consumer accepts the word; meaningful only while Data_valid=1.
- Parity_err  out  1  parity result for the word currently in Data_out.
- Frame_err  out  1  one-cycle pulse when a stop bit is sampled as 1.
- Overrun  out  1  sticky; set when a completed word is dropped.
- Busy  out  1  1 whenever the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE -> DATA on an enabled sample with Serial_in=1 (start bit); clear the bit counter.
  - DATA: shift the sampled bit into the assembly register, LSB first. After DATA_W samples, go to PARITY if PARITY_EN=1, else to STOP.
  - PARITY: latch the sampled bit, then go to STOP.
  - STOP: sample the stop bit, then go to IDLE.
    - Stop bit = 0: the frame completes.
    - Stop bit = 1: pulse Frame_err and discard the word. That 1 is not taken as a new start bit.
- Enable=0: the FSM, counter and assembly register hold their values. Handshake and outputs still update.
- Parity check: Parity_err = XOR of the data bits XOR the parity bit; 1 means an even-parity failure.
- On frame completion:
  - If Data_valid=0, or Data_ack=1 on the same edge: load Data_out and Parity_err, and set Data_valid=1.
  - Otherwise: drop the word, set Overrun and leave Data_out unchanged.
- Data_ack=1 while Data_valid=1 clears Data_valid on that edge, unless a completion reloads it on the same edge.
- Data_ack while Data_valid=0 is ignored.
- Overrun clears only on reset.
- Bit counter is sized ceil(log2(DATA_W+1)) and never wraps past DATA_W.

## Timing
- Reset=0, at any time and asynchronously:
  - state = IDLE.
  - Data_out = 0, Data_valid = 0, Parity_err = 0, Frame_err = 0, Overrun = 0, Busy = 0.
  - Counter and assembly register = 0.
- Reset deasserted mid-frame: reception restarts in IDLE. Partial bits are lost, with no error flags.
- Latency: a frame takes 1 + DATA_W + PARITY_EN + 1 enabled samples. Data_valid is high immediately after the edge that samples the stop bit.
  - Defaults: 7 enabled edges.
- Busy rises after the start-bit edge and falls after the stop-bit edge.
- Frame_err is high for exactly the one cycle after the failing stop-bit edge.
- Back-to-back frames: the start bit may be sampled on the enabled edge right after the stop bit, with no idle gap required.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Clean frame, defaults, Enable=1 throughout: Serial_in = 1,1,0,1,1,1,0 (start; data 1,0,1,1; parity 1; stop 0).
  - Required: Data_out=4'hD, Data_valid=1 after edge 7, Parity_err=0, Frame_err=0.
  - Then Data_ack=1 for one cycle -> Data_valid=0.
- Parity fault: same frame with parity bit 0 -> Data_out=4'hD, Data_valid=1, Parity_err=1.
- Framing fault: Serial_in = 1,0,0,1,0,0,1 (stop bit 1).
  - Required: Frame_err=1 for one cycle, Data_valid stays 0, state returns to IDLE.
  - Then the next 0 samples keep Busy=0.
- Overrun: receive 4'hD and withhold Data_ack, then receive a second frame carrying 4'h2.
  - Required: Overrun=1, Data_out stays 4'hD.
  - Repeat with Data_ack=1 on the second stop-bit edge -> Data_out=4'h2, Data_valid=1, Overrun=0.
- Enable gaps: the clean frame with Enable=0 on every other cycle -> same result as the clean frame, with Data_valid after 14 clocks.
- Reset mid-frame: pull Reset low after the third data bit, release it, then send the clean frame.
  - Required: all outputs are 0 during reset, and the result is 4'hD with no error flags.

Source files
------------

// File: rtl/serial_frame_receiver.sv
// rtl/serial_frame_receiver.sv - start/data/parity/stop serial deframer with valid/ack word handoff
module serial_frame_receiver #(
  parameter int DATA_W    = 4,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Serial_in,
  input  logic              Enable,
  output logic [DATA_W-1:0] Data_out,
  output logic              Data_valid,
  input  logic              Data_ack,
  output logic              Parity_err,
  output logic              Frame_err,
  output logic              Overrun,
  output logic              Busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              parity_bit;
  logic [DATA_W:0]   shift_ext;
  logic              word_parity_err;

  // New bits enter at the MSB so the first bit received ends up in bit 0.
  always_comb begin
    shift_ext = {Serial_in, shift_reg};
  end

  always_comb begin
    word_parity_err = 1'b0;
    if (PARITY_EN) begin
      word_parity_err = (^shift_reg) ^ parity_bit;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      Data_out   <= '0;
      Data_valid <= 1'b0;
      Parity_err <= 1'b0;
      Frame_err  <= 1'b0;
      Overrun    <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      Frame_err <= 1'b0;
      if (Data_valid && Data_ack) begin
        Data_valid <= 1'b0;
      end

      if (Enable) begin
        case (state)
          IDLE: begin
            if (Serial_in) begin
              state   <= DATA;
              bit_cnt <= '0;
              Busy    <= 1'b1;
            end
          end

          DATA: begin
            shift_reg <= shift_ext[DATA_W:1];
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              bit_cnt <= CNT_W'(DATA_W);
              state   <= PARITY_EN ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end

          PARITY: begin
            parity_bit <= Serial_in;
            state      <= STOP;
          end

          STOP: begin
            state <= IDLE;
            Busy  <= 1'b0;
            if (Serial_in) begin
              Frame_err <= 1'b1;
            end else if (!Data_valid || Data_ack) begin
              // A same-edge ack frees the holding register, so the new word wins.
              Data_out   <= shift_reg;
              Parity_err <= word_parity_err;
              Data_valid <= 1'b1;
            end else begin
              Overrun <= 1'b1;
            end
          end

          default: begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb/tb_serial_frame_receiver.sv - scoreboard bench for serial_frame_receiver with frame-level reference model
module tb_serial_frame_receiver;

  logic       CLK;
  logic       Reset;
  logic       Serial_in;
  logic       Enable;
  logic [3:0] Data_out;
  logic       Data_valid;
  logic       Data_ack;
  logic       Parity_err;
  logic       Frame_err;
  logic       Overrun;
  logic       Busy;

  serial_frame_receiver #(.DATA_W(4), .PARITY_EN(1'b1)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Serial_in (Serial_in),
    .Enable    (Enable),
    .Data_out  (Data_out),
    .Data_valid(Data_valid),
    .Data_ack  (Data_ack),
    .Parity_err(Parity_err),
    .Frame_err (Frame_err),
    .Overrun   (Overrun),
    .Busy      (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit       ferr;
    bit [3:0] data;
    bit       perr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   m_valid  = 1'b0;
  bit   m_overrun = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input bit ser, input bit en, input bit ack);
    Serial_in = ser;
    Enable    = en;
    Data_ack  = ack;
    @(posedge CLK);
    #1;
  endtask

  // Frame-level model: a frame either delivers its word, overruns, or reports a framing error.
  task automatic send_frame(input bit [3:0] d, input bit p, input bit stop,
                            input int gap_pct, input bit ack_stop);
    bit bits[7];
    bits[0] = 1'b1;
    for (int i = 0; i < 4; i++) bits[i+1] = d[i];
    bits[5] = p;
    bits[6] = stop;
    for (int i = 0; i < 7; i++) begin
      while (int'($urandom_range(99)) < gap_pct) step(1'($urandom_range(1)), 1'b0, 1'b0);
      step(bits[i], 1'b1, (i == 6) && ack_stop);
    end
    if (ack_stop) m_valid = 1'b0;
    if (stop) begin
      sb.push_back('{ferr: 1'b1, data: 4'h0, perr: 1'b0});
    end else if (m_valid) begin
      m_overrun = 1'b1;
    end else begin
      sb.push_back('{ferr: 1'b0, data: d, perr: (^d) ^ p});
      m_valid = 1'b1;
    end
  endtask

  task automatic ack_word();
    step(1'b0, 1'($urandom_range(1)), 1'b1);
    m_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data_out"},   32'(Data_out),   32'h0);
    chk({tag, "_data_valid"}, 32'(Data_valid), 32'h0);
    chk({tag, "_parity_err"}, 32'(Parity_err), 32'h0);
    chk({tag, "_frame_err"},  32'(Frame_err),  32'h0);
    chk({tag, "_overrun"},    32'(Overrun),    32'h0);
    chk({tag, "_busy"},       32'(Busy),       32'h0);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    #1;
    check_reset_outputs("reset");
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    Reset     = 1'b1;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
  endtask

  // Monitor: a word is presented when valid rises or is reloaded right after an accepted ack.
  initial begin : monitor
    bit   prev_valid = 1'b0;
    bit   prev_ack   = 1'b0;
    bit   prev_ferr  = 1'b0;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (Reset) begin
        if (Data_valid && (!prev_valid || prev_ack)) begin
          if (sb.size() == 0) begin
            chk("unexpected_word", 32'(Data_out), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("sb_kind_word", 32'(e.ferr), 32'h0);
            chk("sb_data_out", 32'(Data_out), 32'(e.data));
            chk("sb_parity_err", 32'(Parity_err), 32'(e.perr));
          end
        end
        if (Frame_err) begin
          chk("frame_err_one_cycle", 32'(prev_ferr), 32'h0);
          if (sb.size() == 0) begin
            chk("unexpected_frame_err", 32'h1, 32'h0);
          end else begin
            e = sb.pop_front();
            chk("sb_kind_ferr", 32'(e.ferr), 32'h1);
          end
        end
      end
      prev_valid = Data_valid;
      prev_ack   = Data_valid && Data_ack;
      prev_ferr  = Frame_err;
    end
  end

  initial begin : stimulus
    bit ebits[7];
    Reset     = 1'b0;
    Serial_in = 1'b0;
    Enable    = 1'b0;
    Data_ack  = 1'b0;
    #1;
    check_reset_outputs("por");
    do_reset();
    step(1'b0, 1'b1, 1'b0);

    // Clean frame
    send_frame(4'hD, 1'b1, 1'b0, 0, 1'b0);
    chk("clean_valid", 32'(Data_valid), 32'h1);
    chk("clean_data", 32'(Data_out), 32'hD);
    chk("clean_perr", 32'(Parity_err), 32'h0);
    chk("clean_ferr", 32'(Frame_err), 32'h0);
    chk("clean_busy", 32'(Busy), 32'h0);
    ack_word();
    chk("clean_ack_clears", 32'(Data_valid), 32'h0);

    // Parity fault
    send_frame(4'hD, 1'b0, 1'b0, 0, 1'b0);
    chk("parity_valid", 32'(Data_valid), 32'h1);
    chk("parity_perr", 32'(Parity_err), 32'h1);
    ack_word();

    // Framing fault: 1,0,0,1,0,0,1
    send_frame(4'h4, 1'b0, 1'b1, 0, 1'b0);
    chk("frame_ferr", 32'(Frame_err), 32'h1);
    chk("frame_valid", 32'(Data_valid), 32'h0);
    chk("frame_busy", 32'(Busy), 32'h0);
    step(1'b0, 1'b1, 1'b0);
    chk("frame_ferr_drop", 32'(Frame_err), 32'h0);
    chk("frame_idle_busy0", 32'(Busy), 32'h0);
    step(1'b0, 1'b1, 1'b0);
    chk("frame_idle_busy1", 32'(Busy), 32'h0);

    // Overrun without ack
    send_frame(4'hD, 1'b1, 1'b0, 0, 1'b0);
    send_frame(4'h2, 1'b1, 1'b0, 0, 1'b0);
    chk("ovr_overrun", 32'(Overrun), 32'h1);
    chk("ovr_data_kept", 32'(Data_out), 32'hD);
    chk("ovr_valid", 32'(Data_valid), 32'h1);
    do_reset();

    // Ack on the second stop edge avoids overrun
    send_frame(4'hD, 1'b1, 1'b0, 0, 1'b0);
    send_frame(4'h2, 1'b1, 1'b0, 0, 1'b1);
    chk("ackstop_data", 32'(Data_out), 32'h2);
    chk("ackstop_valid", 32'(Data_valid), 32'h1);
    chk("ackstop_overrun", 32'(Overrun), 32'h0);
    ack_word();

    // Enable on every other cycle: 14 clocks to valid
    ebits = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 14; i++) begin
      step(ebits[i/2], 1'(i % 2), 1'b0);
      if (i == 12) chk("gap_valid_early", 32'(Data_valid), 32'h0);
    end
    sb.push_back('{ferr: 1'b0, data: 4'hD, perr: 1'b0});
    m_valid = 1'b1;
    chk("gap_valid", 32'(Data_valid), 32'h1);
    chk("gap_data", 32'(Data_out), 32'hD);
    ack_word();

    // Reset after the third data bit
    step(1'b1, 1'b1, 1'b0);
    chk("mid_busy", 32'(Busy), 32'h1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    do_reset();
    send_frame(4'hD, 1'b1, 1'b0, 0, 1'b0);
    chk("mid_data", 32'(Data_out), 32'hD);
    chk("mid_valid", 32'(Data_valid), 32'h1);
    chk("mid_perr", 32'(Parity_err), 32'h0);
    chk("mid_overrun", 32'(Overrun), 32'h0);
    ack_word();

    // Randomized frames with gaps, faults, acks and overruns
    for (int n = 0; n < 200; n++) begin
      send_frame(4'($urandom_range(15)), 1'($urandom_range(1)), $urandom_range(9) == 0,
                 30, $urandom_range(3) == 0);
      for (int k = int'($urandom_range(3)); k > 0; k--) begin
        if ($urandom_range(2) == 0) ack_word();
        else step(1'b0, 1'($urandom_range(1)), 1'b0);
      end
    end
    chk("rand_overrun", 32'(Overrun), 32'(m_overrun));
    chk("rand_valid", 32'(Data_valid), 32'(m_valid));
    ack_word();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
